// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_arb_pkg
//  Description : Shared types and constants for the u_xmit round-robin
//                arbiter (FSM state encoding, pointer width helper).
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_arb_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_LAUNCH    = 2'd1,
        ARB_WAIT_LOW  = 2'd2,
        ARB_WAIT_DONE = 2'd3
    } arb_state_t;

    // Default requester count and the matching pointer width
    localparam int c_ARB_NUM_REQ_DEF = 4;
    localparam int c_ARB_PTR_W       = $clog2(c_ARB_NUM_REQ_DEF);

    // Pointer width for an arbitrary requester count (never below one bit)
    function automatic int arb_ptr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_xmit_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_xmit_arb_if
//  Description : Requester / transmitter bundle for uart_xmit_arb. The slave
//                modport is the arbiter; master is the requester+u_xmit side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_xmit_arb_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_gnt;
    logic [NUM_REQ-1:0]   req_done;
    logic                 arb_busy;
    logic                 timeout_err;
    logic                 xmitH;
    logic [7:0]           xmit_dataH;
    logic                 xmit_doneH;

    modport master (
        output req_valid, req_data, xmit_doneH,
        input  req_gnt, req_done, arb_busy, timeout_err, xmitH, xmit_dataH
    );

    modport slave (
        input  req_valid, req_data, xmit_doneH,
        output req_gnt, req_done, arb_busy, timeout_err, xmitH, xmit_dataH
    );
endinterface
`default_nettype wire

// File: rtl/uart_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rr_pick
//  Description : Combinational rotate-priority encoder. Returns the first set
//                request at or above the pointer, wrapping to index 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  wire logic [NUM_REQ-1:0]             i_req,
    input  wire logic [arb_ptr_w(NUM_REQ)-1:0]  i_ptr,
    output logic      [NUM_REQ-1:0]             o_onehot,
    output logic      [arb_ptr_w(NUM_REQ)-1:0]  o_idx,
    output logic                                o_any
);

    localparam int c_PTR_W = arb_ptr_w(NUM_REQ);

    assign o_any = |i_req;

    // Scan from the farthest candidate back to the pointer so the nearest hit wins
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (i_req[(int'(i_ptr) + k) % NUM_REQ]) begin
                o_onehot = NUM_REQ'(1) << ((int'(i_ptr) + k) % NUM_REQ);
                o_idx    = c_PTR_W'((int'(i_ptr) + k) % NUM_REQ);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_xmit_arb.sv
`default_nettype none
// ============================================================================
//  Module      : uart_xmit_arb
//  Description : Round-robin arbiter/sequencer sharing one u_xmit transmitter
//                among NUM_REQ byte requesters.
//                Optional watchdog abort: define UART_ARB_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_xmit_arb
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  wire logic          sys_clk,
    input  wire logic          sys_rst_l,
    uart_xmit_arb_if.slave     arb_if
);

    localparam int c_PTR_W = arb_ptr_w(NUM_REQ);

    // Elaboration-time range guard on the configuration
    if ((NUM_REQ < 2) || (NUM_REQ > 8) || (TIMEOUT_CYC < 1) || (TIMEOUT_CYC > 65535)) begin : g_param_bad
        $error("uart_xmit_arb: parameter out of range");
    end

    arb_state_t              r_state, w_state_nxt;
    logic [NUM_REQ-1:0]      r_gnt, w_gnt_nxt;
    logic [NUM_REQ-1:0]      r_done, w_done_nxt;
    logic [c_PTR_W-1:0]      r_idx, w_idx_nxt;
    logic [c_PTR_W-1:0]      r_ptr, w_ptr_nxt;
    logic [7:0]              r_data, w_data_nxt;
    logic                    r_xmit, w_xmit_nxt;
    logic                    r_tout, w_tout_nxt;

    logic [NUM_REQ-1:0]      w_pick_onehot;
    logic [c_PTR_W-1:0]      w_pick_idx;
    logic                    w_pick_any;
    logic [7:0]              w_sel_byte;
    logic [c_PTR_W-1:0]      w_ptr_inc;

`ifdef UART_ARB_TIMEOUT_EN
    localparam logic [15:0]  c_TMO = 16'(TIMEOUT_CYC);
    logic [15:0]             r_cnt, w_cnt_nxt;
`endif

    uart_rr_pick #(
        .NUM_REQ  (NUM_REQ)
    ) u_pick (
        .i_req    (arb_if.req_valid),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    assign w_sel_byte = arb_if.req_data[int'(w_pick_idx) * 8 +: 8];
    assign w_ptr_inc  = (r_idx == c_PTR_W'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;

    // State register and all registered outputs
    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            r_state <= ARB_IDLE;
            r_gnt   <= '0;
            r_done  <= '0;
            r_idx   <= '0;
            r_ptr   <= '0;
            r_data  <= 8'h00;
            r_xmit  <= 1'b0;
            r_tout  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            r_cnt   <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_done  <= w_done_nxt;
            r_idx   <= w_idx_nxt;
            r_ptr   <= w_ptr_nxt;
            r_data  <= w_data_nxt;
            r_xmit  <= w_xmit_nxt;
            r_tout  <= w_tout_nxt;
`ifdef UART_ARB_TIMEOUT_EN
            r_cnt   <= w_cnt_nxt;
`endif
        end
    end

    // Next-state and next-output logic; pulses default low every cycle
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_done_nxt  = '0;
        w_idx_nxt   = r_idx;
        w_ptr_nxt   = r_ptr;
        w_data_nxt  = r_data;
        w_xmit_nxt  = 1'b0;
        w_tout_nxt  = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        w_cnt_nxt   = r_cnt;
`endif
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_any) begin
                    w_gnt_nxt   = w_pick_onehot;
                    w_idx_nxt   = w_pick_idx;
                    w_data_nxt  = w_sel_byte;
                    w_state_nxt = ARB_LAUNCH;
                end
            end
            ARB_LAUNCH: begin
                // xmitH is registered, so it is high during the first WAIT_LOW cycle
                w_xmit_nxt  = 1'b1;
                w_state_nxt = ARB_WAIT_LOW;
`ifdef UART_ARB_TIMEOUT_EN
                w_cnt_nxt   = '0;
`endif
            end
            ARB_WAIT_LOW: begin
                if (!arb_if.xmit_doneH) begin
                    w_state_nxt = ARB_WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_TMO) begin
                    w_tout_nxt  = 1'b1;
                    w_gnt_nxt   = '0;
                    w_ptr_nxt   = w_ptr_inc;
                    w_state_nxt = ARB_IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt + 16'd1;
`endif
                end
            end
            ARB_WAIT_DONE: begin
                if (arb_if.xmit_doneH) begin
                    w_done_nxt  = r_gnt;
                    w_gnt_nxt   = '0;
                    w_ptr_nxt   = w_ptr_inc;
                    w_state_nxt = ARB_IDLE;
`ifdef UART_ARB_TIMEOUT_EN
                end else if (r_cnt == c_TMO) begin
                    w_tout_nxt  = 1'b1;
                    w_gnt_nxt   = '0;
                    w_ptr_nxt   = w_ptr_inc;
                    w_state_nxt = ARB_IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt + 16'd1;
`endif
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    assign arb_if.req_gnt    = r_gnt;
    assign arb_if.req_done   = r_done;
    assign arb_if.arb_busy   = (r_state != ARB_IDLE);
    assign arb_if.xmitH      = r_xmit;
    assign arb_if.xmit_dataH = r_data;
`ifdef UART_ARB_TIMEOUT_EN
    assign arb_if.timeout_err = r_tout;
`else
    assign arb_if.timeout_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_xmit_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_xmit_arb
//  Description : Directed self-checking bench for uart_xmit_arb (NUM_REQ=4,
//                TIMEOUT_CYC=20). The bench plays the role of u_xmit by
//                driving xmit_doneH by hand.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_xmit_arb;

    logic clk;
    logic rst_l;
    int   checks;
    int   errors;

    uart_xmit_arb_if #(.NUM_REQ(4)) bus ();

    uart_xmit_arb #(
        .NUM_REQ     (4),
        .TIMEOUT_CYC (20)
    ) dut (
        .sys_clk   (clk),
        .sys_rst_l (rst_l),
        .arb_if    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One complete transfer: wait for the grant, then emulate u_xmit 1->0->1
    task automatic serve(input string tag, input logic [3:0] eg, input logic [7:0] eb,
                         input logic [3:0] drop, input bit chg);
        int n;
        n = 0;
        while (bus.req_gnt === 4'b0000 && n < 20) begin
            cyc();
            n++;
        end
        chk({tag, "_gnt"},   32'(bus.req_gnt),    32'(eg));
        chk({tag, "_data"},  32'(bus.xmit_dataH), 32'(eb));
        chk({tag, "_xmit0"}, 32'(bus.xmitH),      32'd0);
        chk({tag, "_nodn0"}, 32'(bus.req_done),   32'd0);
        if (chg) bus.req_data[7:0] = 8'hFF;
        cyc();
        chk({tag, "_xmit1"}, 32'(bus.xmitH),      32'd1);
        bus.xmit_doneH = 1'b0;
        cyc();
        chk({tag, "_xmit2"}, 32'(bus.xmitH),      32'd0);
        chk({tag, "_nodn1"}, 32'(bus.req_done),   32'd0);
        cyc();
        chk({tag, "_nodn2"}, 32'(bus.req_done),   32'd0);
        chk({tag, "_hold"},  32'(bus.req_gnt),    32'(eg));
        bus.xmit_doneH = 1'b1;
        cyc();
        chk({tag, "_done"},  32'(bus.req_done),   32'(eg));
        chk({tag, "_gclr"},  32'(bus.req_gnt),    32'd0);
        chk({tag, "_dkeep"}, 32'(bus.xmit_dataH), 32'(eb));
        chk({tag, "_idle"},  32'(bus.arb_busy),   32'd0);
        bus.req_valid = bus.req_valid & ~drop;
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst_l          = 1'b0;
        bus.req_valid  = 4'b0000;
        bus.req_data   = 32'h0;
        bus.xmit_doneH = 1'b1;

        // Reset state
        #12;
        chk("rst_gnt",  32'(bus.req_gnt),     32'd0);
        chk("rst_done", 32'(bus.req_done),    32'd0);
        chk("rst_busy", 32'(bus.arb_busy),    32'd0);
        chk("rst_tout", 32'(bus.timeout_err), 32'd0);
        chk("rst_xmit", 32'(bus.xmitH),       32'd0);
        chk("rst_data", 32'(bus.xmit_dataH),  32'd0);
        cyc();
        rst_l = 1'b1;
        cyc();

        // Single request on index 2
        bus.req_data[23:16] = 8'hA5;
        bus.req_valid       = 4'b0100;
        cyc();
        chk("t1_gnt_next", 32'(bus.req_gnt),  32'h4);
        chk("t1_busy",     32'(bus.arb_busy), 32'd1);
        serve("t1", 4'b0100, 8'hA5, 4'b1111, 1'b0);
        cyc();
        chk("t1_pulse1", 32'(bus.req_done), 32'd0);

        // All four continuously valid from a fresh reset: 0,1,2,3,0
        rst_l = 1'b0;
        cyc();
        rst_l = 1'b1;
        bus.req_data  = 32'h4332_2110;
        bus.req_valid = 4'b1111;
        serve("rr0", 4'b0001, 8'h10, 4'b0000, 1'b0);
        serve("rr1", 4'b0010, 8'h21, 4'b0000, 1'b0);
        serve("rr2", 4'b0100, 8'h32, 4'b0000, 1'b0);
        serve("rr3", 4'b1000, 8'h43, 4'b0000, 1'b0);
        serve("rr4", 4'b0001, 8'h10, 4'b1111, 1'b0);

        // Pointer fairness: serve 2 alone, then 0 and 2 together -> 0 then 2
        cyc();
        bus.req_valid = 4'b0100;
        serve("pf2", 4'b0100, 8'h32, 4'b0100, 1'b0);
        bus.req_valid = 4'b0101;
        serve("pf0", 4'b0001, 8'h10, 4'b0001, 1'b0);
        serve("pf2b", 4'b0100, 8'h32, 4'b0100, 1'b0);

        // Data change after grant must not reach xmit_dataH
        cyc();
        bus.req_data[7:0] = 8'h55;
        bus.req_valid     = 4'b0001;
        serve("dchg", 4'b0001, 8'h55, 4'b0001, 1'b1);

        // Reset in WAIT_DONE: async clear, no done, pointer back to 0
        cyc();
        bus.req_data[15:8] = 8'h66;
        bus.req_valid      = 4'b0010;
        cyc();
        chk("mr_gnt", 32'(bus.req_gnt), 32'h2);
        cyc();
        bus.xmit_doneH = 1'b0;
        cyc();
        cyc();
        rst_l = 1'b0;
        #1;
        chk("mr_gnt0",  32'(bus.req_gnt),    32'd0);
        chk("mr_busy0", 32'(bus.arb_busy),   32'd0);
        chk("mr_data0", 32'(bus.xmit_dataH), 32'd0);
        chk("mr_done0", 32'(bus.req_done),   32'd0);
        bus.xmit_doneH = 1'b1;
        cyc();
        chk("mr_done1", 32'(bus.req_done), 32'd0);
        rst_l         = 1'b1;
        bus.req_data[7:0] = 8'h77;
        bus.req_valid = 4'b0011;
        serve("mr_next", 4'b0001, 8'h77, 4'b0011, 1'b0);

`ifdef UART_ARB_TIMEOUT_EN
        // Watchdog: u_xmit never drops done; pointer is 1 here
        begin
            int n;
            int dn;
            bit seen;
            cyc();
            bus.req_data[23:16] = 8'h99;
            bus.req_valid = 4'b0110;
            cyc();
            chk("to_gnt", 32'(bus.req_gnt), 32'h2);
            seen = 1'b0;
            dn   = 0;
            n    = 0;
            while (!seen && n < 60) begin
                cyc();
                n++;
                if (bus.req_done !== 4'b0000) dn++;
                if (bus.timeout_err === 1'b1) seen = 1'b1;
            end
            chk("to_seen",  32'(seen),           32'd1);
            chk("to_nodn",  32'(dn),             32'd0);
            chk("to_gclr",  32'(bus.req_gnt),    32'd0);
            chk("to_busy",  32'(bus.arb_busy),   32'd0);
            cyc();
            chk("to_pulse", 32'(bus.timeout_err), 32'd0);
            serve("to_next", 4'b0100, 8'h99, 4'b0110, 1'b0);
        end
`else
        chk("tout_tied", 32'(bus.timeout_err), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_xmit_arb.md
Name: uart_xmit_arb

Overview:
- Round-robin arbiter and sequencer sharing one u_xmit transmitter among NUM_REQ byte requesters.
- Sits between requester logic (command/response engines) and u_xmit.
- Drives xmitH and xmit_dataH, tracks xmit_doneH, and returns a per-requester completion pulse.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYC, 65535, watchdog limit in sys_clk cycles. Used only with UART_ARB_TIMEOUT_EN.

Ports:
- sys_clk  input  1  system clock, all logic on posedge.
- sys_rst_l  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester byte request; held until matching req_done.
- req_data  input  8*NUM_REQ  byte i at [8*i+7:8*i]; held stable with req_valid.
- req_gnt  output  NUM_REQ  one-hot grant, high from capture until completion.
- req_done  output  NUM_REQ  one-cycle pulse on the granted bit when its byte finishes.
- arb_busy  output  1  high in every state except IDLE.
- timeout_err  output  1  one-cycle pulse on watchdog abort; constant 0 without the macro.
- xmitH  output  1  start pulse to u_xmit.
- xmit_dataH  output  8  byte to u_xmit.
- xmit_doneH  input  1  u_xmit done flag: low while shifting, high when finished or idle.

Behaviour:
- Reset (async, sys_rst_l=0) clears all outputs and internal registers:
  - req_gnt=0, req_done=0, arb_busy=0, timeout_err=0, xmitH=0, xmit_dataH=8'h00.
  - Round-robin pointer=0; state=IDLE.
- State machine IDLE -> LAUNCH -> WAIT_LOW -> WAIT_DONE -> IDLE.
- IDLE:
  - If any req_valid bit is set, pick the first set bit searching upward from the pointer, wrapping from NUM_REQ-1 to 0.
  - On that edge: register req_gnt one-hot, capture the selected byte into xmit_dataH, go to LAUNCH.
- LAUNCH: xmitH=1 for exactly one cycle; go to WAIT_LOW.
- WAIT_LOW: stay until xmit_doneH=0 (transmitter accepted the byte); then go to WAIT_DONE.
- WAIT_DONE: on the first cycle with xmit_doneH=1:
  - Pulse req_done for the granted bit for one cycle and clear req_gnt on the same edge.
  - Set pointer = granted index + 1, modulo NUM_REQ; go to IDLE.
- Latency:
  - req_valid seen in IDLE -> req_gnt and xmit_dataH valid next edge.
  - xmitH high the cycle after that.
  - Minimum request-to-done = 3 cycles + transmitter time.
- Back-to-back: IDLE re-arbitrates the cycle after req_done. A requester keeping req_valid high is served again only after every other pending requester.
- xmit_dataH holds the captured byte from grant until the next grant. It ignores later req_data changes.
- If req_valid drops after grant, the transfer still completes and req_done still pulses.
- req_valid rising in any non-IDLE state waits; it is not lost.
- Simultaneous requests: the pointer decides. Index 0 wins after reset.
- Only one req_done bit is ever high at a time. req_gnt is never multi-hot.
- Reset asserted mid-transfer aborts immediately. No req_done is issued; the pointer returns to 0.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- With the macro:
  - A 16-bit counter clears on entry to WAIT_LOW and WAIT_DONE and increments each cycle in those states.
  - When it reaches TIMEOUT_CYC: pulse timeout_err for one cycle, clear req_gnt, do not pulse req_done, advance the pointer past the granted index, and return to IDLE.
- Without the macro: no counter; timeout_err tied 0; the FSM waits indefinitely.

Decomposition:
- Package uart_arb_pkg holds:
  - FSM state encoding: ARB_IDLE=2'd0, ARB_LAUNCH=2'd1, ARB_WAIT_LOW=2'd2, ARB_WAIT_DONE=2'd3.
  - Pointer width constant (clog2 of NUM_REQ).
- One sub-module, uart_rr_pick: a combinational rotate-priority encoder taking req_valid and the pointer, returning a one-hot winner and its index. The FSM, capture registers and watchdog stay in uart_xmit_arb.

Test Plan:
- Reset then single request: req_valid=4'b0100, byte 8'hA5.
  - Expect req_gnt=4'b0100 next cycle, xmitH pulse the cycle after, xmit_dataH=8'hA5.
  - After the bench drives xmit_doneH 1->0->1, expect req_done=4'b0100 for one cycle.
- All four valid continuously (bytes 8'h10, 8'h21, 8'h32, 8'h43): grant order is 0,1,2,3,0.
  - Each xmit_dataH matches its requester's byte.
  - Exactly one req_done per transfer.
- Pointer fairness: after serving index 2, assert req_valid=4'b0101. Index 0 wins next, then index 2.
- Data change after grant: change req_data[0] from 8'h55 to 8'hFF after req_gnt. xmit_dataH stays 8'h55 through req_done.
- Reset mid-WAIT_DONE: pulse sys_rst_l low. All outputs go to 0 asynchronously, with no req_done. Next grant goes to index 0.
- With UART_ARB_TIMEOUT_EN and TIMEOUT_CYC=20: hold xmit_doneH=1 after xmitH.
  - timeout_err pulses once, no req_done, arb_busy drops.
  - The next pending requester is granted.
